// File: rtl/gb_interrupt_ctrl.sv
// Interrupt controller: IF/IE registers, IRQ rising-edge capture, priority vector, IME state machine with delayed EI.
// Latency: irq edge sets IF at the next edge; wake/interrupt_queued/vector follow IF and IE combinationally.
// Backpressure: none; the CPU takes an interrupt with isr_ack, and bus reads/writes are never stalled.
//
// Ports:
//   clk, reset               M-cycle clock, asynchronous active-high reset
//   irq_req                  peripheral request lines (rising edge sets IF)
//   bus_addr/wdata/we/rdata  register bus for IF and IE; bus_hit flags a decoded address
//   ei/di/reti_cmd           IME control from the CPU; instr_done marks the last M-cycle of an instruction
//   isr_ack                  CPU dispatching an interrupt this cycle
//   ime, interrupt_queued, wake, interrupt_vector   status toward the CPU
//   vector_latched, irq_taken                       record of the last acknowledge
module gb_interrupt_ctrl #(
  parameter int          NUM_IRQ       = 5,
  parameter logic [7:0]  VECTOR_BASE   = 8'h40,
  parameter int          VECTOR_STRIDE = 8,
  parameter logic [15:0] IF_ADDR       = 16'hFF0F,
  parameter logic [15:0] IE_ADDR       = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [15:0]        bus_addr,
  input  logic [7:0]         bus_wdata,
  input  logic               bus_we,
  output logic [7:0]         bus_rdata,
  output logic               bus_hit,
  input  logic               ei_cmd,
  input  logic               di_cmd,
  input  logic               reti_cmd,
  input  logic               instr_done,
  input  logic               isr_ack,
  output logic               ime,
  output logic               interrupt_queued,
  output logic               wake,
  output logic [7:0]         interrupt_vector,
  output logic [7:0]         vector_latched,
  output logic [NUM_IRQ-1:0] irq_taken
);

  typedef enum logic [1:0] {
    IME_OFF     = 2'd0,
    IME_PENDING = 2'd1,
    IME_ON      = 2'd2
  } ime_state_t;

  ime_state_t         ime_state;
  logic               ime_q;
  logic [NUM_IRQ-1:0] if_q;
  logic [NUM_IRQ-1:0] if_nxt;
  logic [7:0]         ie_q;
  logic [NUM_IRQ-1:0] req_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] sel_onehot;
  logic               sel_vld;
  logic [7:0]         if_rd;
  logic               if_sel;
  logic               ie_sel;

  function automatic logic [7:0] vec_of(input int idx);
    int v;
    v = int'(VECTOR_BASE) + idx * VECTOR_STRIDE;
    return v[7:0];
  endfunction

  assign if_sel  = (bus_addr == IF_ADDR);
  assign ie_sel  = (bus_addr == IE_ADDR);
  assign bus_hit = if_sel | ie_sel;

  assign rise    = irq_req & ~req_d;
  assign pending = if_q & ie_q[NUM_IRQ-1:0];

  // Walk from the top index down so the lowest pending index is the last write and wins.
  always_comb begin
    sel_vld          = 1'b0;
    sel_onehot       = '0;
    interrupt_vector = 8'h00;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_vld          = 1'b1;
        sel_onehot       = '0;
        sel_onehot[i]    = 1'b1;
        interrupt_vector = vec_of(i);
      end
    end
  end

  // Per bit: a fresh edge beats the acknowledge clear, which beats a bus load.
  always_comb begin
    if_nxt = if_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (rise[i])
        if_nxt[i] = 1'b1;
      else if (isr_ack && sel_onehot[i])
        if_nxt[i] = 1'b0;
      else if (bus_we && if_sel)
        if_nxt[i] = bus_wdata[i];
    end
  end

  // Unimplemented IF bits read as 1.
  always_comb begin
    if_rd              = 8'hFF;
    if_rd[NUM_IRQ-1:0] = if_q;
  end

  always_comb begin
    if (if_sel)
      bus_rdata = if_rd;
    else if (ie_sel)
      bus_rdata = ie_q;
    else
      bus_rdata = 8'hFF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_q           <= '0;
      ie_q           <= 8'h00;
      req_d          <= '0;
      vector_latched <= 8'h00;
      irq_taken      <= '0;
    end else begin
      req_d <= irq_req;
      if_q  <= if_nxt;
      if (bus_we && ie_sel)
        ie_q <= bus_wdata;
      if (isr_ack) begin
        // An empty pending set (cancelled request) yields vector 0 and no source.
        vector_latched <= interrupt_vector;
        irq_taken      <= sel_onehot;
      end
    end
  end

  // IME: DI > RETI > acknowledge > EI / delayed promotion. The EI cycle itself is
  // spent in IME_OFF, so promotion waits for a later instr_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ime_state <= IME_OFF;
      ime_q     <= 1'b0;
    end else if (di_cmd) begin
      ime_state <= IME_OFF;
      ime_q     <= 1'b0;
    end else if (reti_cmd) begin
      ime_state <= IME_ON;
      ime_q     <= 1'b1;
    end else if (isr_ack) begin
      ime_state <= IME_OFF;
      ime_q     <= 1'b0;
    end else begin
      case (ime_state)
        IME_OFF: begin
          if (ei_cmd) begin
            ime_state <= IME_PENDING;
            ime_q     <= 1'b0;
          end
        end
        IME_PENDING: begin
          if (instr_done) begin
            ime_state <= IME_ON;
            ime_q     <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ime              = ime_q;
  assign wake             = sel_vld;
  assign interrupt_queued = ime_q & sel_vld;

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
module tb_gb_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  irq_req = '0;
  logic [15:0] bus_addr = 16'hFF0F;
  logic [7:0]  bus_wdata = '0;
  logic        bus_we = 1'b0;
  logic        ei_cmd = 1'b0, di_cmd = 1'b0, reti_cmd = 1'b0, instr_done = 1'b0, isr_ack = 1'b0;
  logic [7:0]  bus_rdata;
  logic        bus_hit, ime, interrupt_queued, wake;
  logic [7:0]  interrupt_vector, vector_latched;
  logic [4:0]  irq_taken;

  // Second instance: 8 sources, different vector base.
  logic [7:0]  req2 = '0;
  logic [15:0] addr2 = 16'h0000;
  logic [7:0]  wd2 = '0;
  logic        we2 = 1'b0;
  logic [7:0]  rd2, vec2, vl2, taken2;
  logic        hit2, ime2, iq2, wake2;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  gb_interrupt_ctrl dut (
    .clk(clk), .reset(reset), .irq_req(irq_req),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_rdata(bus_rdata), .bus_hit(bus_hit),
    .ei_cmd(ei_cmd), .di_cmd(di_cmd), .reti_cmd(reti_cmd),
    .instr_done(instr_done), .isr_ack(isr_ack),
    .ime(ime), .interrupt_queued(interrupt_queued), .wake(wake),
    .interrupt_vector(interrupt_vector), .vector_latched(vector_latched),
    .irq_taken(irq_taken)
  );

  gb_interrupt_ctrl #(.NUM_IRQ(8), .VECTOR_BASE(8'hC0)) dut8 (
    .clk(clk), .reset(reset), .irq_req(req2),
    .bus_addr(addr2), .bus_wdata(wd2), .bus_we(we2),
    .bus_rdata(rd2), .bus_hit(hit2),
    .ei_cmd(1'b0), .di_cmd(1'b0), .reti_cmd(1'b0),
    .instr_done(1'b0), .isr_ack(1'b0),
    .ime(ime2), .interrupt_queued(iq2), .wake(wake2),
    .interrupt_vector(vec2), .vector_latched(vl2),
    .irq_taken(taken2)
  );

  typedef struct {
    logic       ime, iq, wake, hit;
    logic [7:0] vec, vl, rdata;
    logic [4:0] taken;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: IF/IE as plain arrays, IME as "enabled" plus "EI waiting".
  bit       m_if[5];
  bit [7:0] m_ie;
  bit       m_old[5];
  bit       m_ime, m_ei_wait;
  bit [7:0] m_vl;
  bit [4:0] m_taken;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask

  function automatic int lowest_pending();
    for (int i = 0; i < 5; i++)
      if (m_if[i] && m_ie[i]) return i;
    return -1;
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    int   p;
    bit [7:0] ifv;
    p = lowest_pending();
    ifv = 8'hE0;
    for (int i = 0; i < 5; i++) if (m_if[i]) ifv = ifv + 8'(1 << i);
    e.wake  = (p >= 0);
    e.ime   = m_ime;
    e.iq    = m_ime && (p >= 0);
    e.vec   = (p >= 0) ? 8'(64 + 8 * p) : 8'h00;
    e.vl    = m_vl;
    e.taken = m_taken;
    e.hit   = (bus_addr == 16'hFF0F) || (bus_addr == 16'hFFFF);
    e.rdata = (bus_addr == 16'hFF0F) ? ifv : (bus_addr == 16'hFFFF) ? m_ie : 8'hFF;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin m_if[i] = 0; m_old[i] = 0; end
    m_ie = 0; m_ime = 0; m_ei_wait = 0; m_vl = 0; m_taken = 0;
  endtask

  task automatic model_edge();
    int p;
    p = lowest_pending();
    if (isr_ack) begin
      m_vl    = (p >= 0) ? 8'(64 + 8 * p) : 8'h00;
      m_taken = (p >= 0) ? 5'(1 << p) : 5'd0;
    end
    for (int i = 0; i < 5; i++) begin
      if (irq_req[i] && !m_old[i]) m_if[i] = 1;
      else if (isr_ack && i == p) m_if[i] = 0;
      else if (bus_we && bus_addr == 16'hFF0F) m_if[i] = bus_wdata[i];
      m_old[i] = irq_req[i];
    end
    if (bus_we && bus_addr == 16'hFFFF) m_ie = bus_wdata;
    if (di_cmd) begin m_ime = 0; m_ei_wait = 0; end
    else if (reti_cmd) begin m_ime = 1; m_ei_wait = 0; end
    else if (isr_ack) begin m_ime = 0; m_ei_wait = 0; end
    else if (m_ei_wait && instr_done) begin m_ime = 1; m_ei_wait = 0; end
    else if (ei_cmd && !m_ime) m_ei_wait = 1;
  endtask

  // One M-cycle of stimulus: drive, record the expected outputs, advance the model.
  task automatic cyc(input logic rst, input logic [4:0] req, input logic [15:0] a,
                     input logic [7:0] wd, input logic we, input logic ei, input logic di,
                     input logic reti, input logic idn, input logic ack);
    @(negedge clk);
    reset = rst; irq_req = req; bus_addr = a; bus_wdata = wd; bus_we = we;
    ei_cmd = ei; di_cmd = di; reti_cmd = reti; instr_done = idn; isr_ack = ack;
    if (rst) model_reset();
    #1;
    exp_q.push_back(model_outputs());
    if (!rst) model_edge();
  endtask

  task automatic idle(input int n, input logic [4:0] req);
    for (int i = 0; i < n; i++) cyc(0, req, 16'hFF0F, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops one expectation per cycle and compares against the DUT.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ime", {7'd0, ime}, {7'd0, e.ime});
        chk("interrupt_queued", {7'd0, interrupt_queued}, {7'd0, e.iq});
        chk("wake", {7'd0, wake}, {7'd0, e.wake});
        chk("interrupt_vector", interrupt_vector, e.vec);
        chk("vector_latched", vector_latched, e.vl);
        chk("irq_taken", {3'd0, irq_taken}, {3'd0, e.taken});
        chk("bus_rdata", bus_rdata, e.rdata);
        chk("bus_hit", {7'd0, bus_hit}, {7'd0, e.hit});
      end
      if (exp_q.size() > 3) begin
        n_chk++;
        $display("FAIL scoreboard_backlog: depth %0d, expected at most 3", exp_q.size());
        exp_q.delete();
      end
    end
  end

  initial begin
    logic [4:0]  r;
    logic [15:0] a;
    model_reset();
    cyc(1, 0, 16'hFF0F, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_ime", {7'd0, ime}, 8'd0);
    chk("reset_vector", interrupt_vector, 8'h00);
    idle(1, 0);

    // Priority / vector
    cyc(0, 0, 16'hFFFF, 8'h1F, 1, 0, 0, 0, 0, 0);
    cyc(0, 5'b10100, 16'hFF0F, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 16'hFF0F, 0, 0, 0, 0, 0, 0, 0);
    chk("prio_if", bus_rdata, 8'hF4);
    chk("prio_vector", interrupt_vector, 8'h50);
    cyc(0, 0, 16'hFF0F, 0, 0, 0, 0, 0, 0, 1);
    idle(1, 0);
    chk("ack_if", bus_rdata, 8'hF0);
    chk("ack_latched", vector_latched, 8'h50);
    chk("ack_taken", {3'd0, irq_taken}, 8'h04);
    chk("ack_next_vector", interrupt_vector, 8'h60);

    // EI delay: ei+instr_done at t, instr_done at t+2, queued in t+3
    cyc(0, 0, 16'hFF0F, 0, 0, 1, 0, 0, 1, 0);
    cyc(0, 0, 16'hFF0F, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 16'hFF0F, 0, 0, 0, 0, 0, 1, 0);
    chk("ei_t2_queued", {7'd0, interrupt_queued}, 8'd0);
    idle(1, 0);
    chk("ei_t3_queued", {7'd0, interrupt_queued}, 8'd1);
    // Same with DI in t+1
    cyc(0, 0, 16'hFF0F, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 16'hFF0F, 0, 0, 1, 0, 0, 1, 0);
    cyc(0, 0, 16'hFF0F, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 16'hFF0F, 0, 0, 0, 0, 0, 1, 0);
    idle(2, 0);
    chk("ei_di_queued", {7'd0, interrupt_queued}, 8'd0);

    // RETI, then EI+DI together
    cyc(0, 0, 16'hFF0F, 0, 0, 0, 0, 1, 0, 0);
    idle(1, 0);
    chk("reti_ime", {7'd0, ime}, 8'd1);
    cyc(0, 0, 16'hFF0F, 0, 0, 1, 1, 0, 1, 0);
    idle(1, 0);
    chk("ei_di_ime", {7'd0, ime}, 8'd0);

    // Set beats clear; held request does not re-set
    cyc(0, 5'b00010, 16'hFF0F, 8'h00, 1, 0, 0, 0, 0, 0);
    idle(1, 5'b00010);
    chk("set_beats_clear", bus_rdata, 8'hE2);
    cyc(0, 5'b00010, 16'hFF0F, 8'h00, 1, 0, 0, 0, 0, 0);
    idle(10, 5'b00010);
    chk("held_req_if", bus_rdata, 8'hE0);
    idle(1, 0);

    // Cancelled ack
    cyc(0, 5'b01000, 16'hFF0F, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 16'hFFFF, 8'h00, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 16'hFF0F, 0, 0, 0, 0, 0, 0, 1);
    idle(1, 0);
    chk("cancel_latched", vector_latched, 8'h00);
    chk("cancel_taken", {3'd0, irq_taken}, 8'h00);
    chk("cancel_if", bus_rdata, 8'hE8);

    // Reset mid-operation
    cyc(0, 0, 16'hFF0F, 8'h1F, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 16'hFFFF, 8'hFF, 1, 0, 0, 1, 0, 0);
    idle(1, 0);
    cyc(1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0);
    chk("midreset_ie", bus_rdata, 8'h00);
    chk("midreset_wake", {7'd0, wake}, 8'd0);
    cyc(1, 0, 16'hFF0F, 0, 0, 0, 0, 0, 0, 0);
    chk("midreset_if", bus_rdata, 8'hE0);

    // 8-source instance: source 7 vector
    @(negedge clk); reset = 1'b0; addr2 = 16'hFFFF; wd2 = 8'hFF; we2 = 1'b1;
    @(negedge clk); we2 = 1'b0; req2 = 8'h80;
    @(negedge clk); req2 = 8'h00; #1;
    chk("n8_vector", vec2, 8'hF8);
    chk("n8_wake", {7'd0, wake2}, 8'd1);

    // Randomized traffic
    r = 0;
    for (int n = 0; n < 3000; n++) begin
      r = r ^ 5'($urandom & $urandom & $urandom);
      case ($urandom % 4)
        0: a = 16'hFF0F;
        1: a = 16'hFFFF;
        2: a = 16'($urandom);
        default: a = 16'hFF0F;
      endcase
      cyc(($urandom % 250) == 0, r, a, 8'($urandom), ($urandom % 4) == 0,
          ($urandom % 12) == 0, ($urandom % 16) == 0, ($urandom % 20) == 0,
          1'($urandom), ($urandom % 6) == 0);
    end
    idle(1, r);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gb_interrupt_ctrl.md
Name: gb_interrupt_ctrl

Overview:
Parametrised interrupt controller for the gameboy CPU family. It owns the IF and IE registers, the IME state machine with the delayed-EI rule, and IRQ edge capture. It performs priority selection over IF & IE, generates vectors and runs the CPU acknowledge handshake. It sits between the peripherals, the memory-mapped register bus and the CPU core, which consumes interrupt_queued, wake and the vector.

Parameters:
NUM_IRQ, 5, number of interrupt sources (1..8); bit 0 has the highest priority.
VECTOR_BASE, 8'h40, vector of source 0.
VECTOR_STRIDE, 8, vector spacing between sources.
IF_ADDR, 16'hFF0F, bus address of IF.
IE_ADDR, 16'hFFFF, bus address of IE.

Ports:
clk  input  1  machine (M) clock; the single clock.
reset  input  1  asynchronous, active-high reset.
irq_req  input  NUM_IRQ  peripheral request lines; a rising edge sets the matching IF bit.
bus_addr  input  16  register bus address.
bus_wdata  input  8  register bus write data.
bus_we  input  1  register bus write strobe.
bus_rdata  output  8  combinational read data for IF_ADDR or IE_ADDR; 8'hFF for any other address.
bus_hit  output  1  bus_addr equals IF_ADDR or IE_ADDR.
ei_cmd  input  1  EI executed this cycle.
di_cmd  input  1  DI executed this cycle.
reti_cmd  input  1  RETI executed this cycle.
instr_done  input  1  current cycle is the last M-cycle of an instruction.
isr_ack  input  1  CPU is dispatching an interrupt this cycle.
ime  output  1  interrupt master enable, 1 only in state IME_ON.
interrupt_queued  output  1  ime & (pending != 0).
wake  output  1  pending != 0, regardless of IME (HALT exit and halt-bug detection).
interrupt_vector  output  8  combinational vector of the highest-priority pending source; 8'h00 when none.
vector_latched  output  8  vector captured on isr_ack.
irq_taken  output  NUM_IRQ  one-hot registered source serviced by the last isr_ack.

Behaviour:
- pending = IF & IE[NUM_IRQ-1:0]. Priority goes to the lowest set index.
- Vector = VECTOR_BASE + idx*VECTOR_STRIDE, truncated to 8 bits.
- Reset (async): IF=0, IE=0, irq_req history=0, IME state=IME_OFF, vector_latched=8'h00, irq_taken=0.
- After reset, all outputs follow from these register values: ime=0, interrupt_queued=0, wake=0, interrupt_vector=8'h00.
- Edge capture: req_d <= irq_req each cycle. rise = irq_req & ~req_d. A request held high sets IF only once.
- IF update, in priority order per bit:
  - rise sets the bit;
  - else isr_ack clears the selected bit;
  - else a bus write to IF_ADDR loads bus_wdata[NUM_IRQ-1:0].
  - A set always beats a clear in the same cycle.
- IF read: {1s in bits 7..NUM_IRQ, IF}.
- IE: full 8-bit read/write storage. Only the low NUM_IRQ bits are used for pending.
- Writes take effect at the next edge. Reads are combinational from the current register values.
- IME FSM, states IME_OFF, IME_PENDING, IME_ON:
  - di_cmd: next state IME_OFF from any state. di_cmd wins over ei_cmd and reti_cmd in the same cycle.
  - reti_cmd (no di): next state IME_ON immediately, at the next edge.
  - ei_cmd (no di/reti): IME_OFF -> IME_PENDING. In IME_PENDING or IME_ON, no change.
  - IME_PENDING -> IME_ON at the edge ending the first cycle after entry with instr_done=1. The cycle containing ei_cmd is never counted. Net effect: the instruction following EI completes before an interrupt can be taken.
  - isr_ack: next state IME_OFF. This has priority over a pending EI promotion in the same cycle.
- Acknowledge on isr_ack:
  - vector_latched <= interrupt_vector and irq_taken <= one-hot of the selected index.
  - If pending is empty at ack time (request cancelled by an IF/IE write), vector_latched <= 8'h00 and irq_taken <= 0, and no IF bit is cleared.
  - The selected source is the one pending at the ack cycle, not the one pending when interrupt_queued first rose.
- isr_ack while ime=0 is still honoured as above. This is a CPU protocol error; no error output.
- Latency: irq edge -> IF set 1 cycle -> wake/interrupt_queued asserted in the following cycle (combinational from IF).

Test Plan:
- Reset mid-operation: IF=5'h1F, IE=8'hFF, IME_ON, assert reset -> immediately ime=0, wake=0, interrupt_vector=8'h00; IE read returns 8'h00, IF read returns 8'hE0.
- Priority/vector: IE=8'h1F, pulse irq_req[2] and irq_req[4] in the same cycle -> next cycle IF=5'b10100, interrupt_vector=8'h50. isr_ack -> IF=5'b10000, vector_latched=8'h50, irq_taken=5'b00100, ime=0, interrupt_vector=8'h60.
- EI delay: IME_OFF, pending≠0, ei_cmd with instr_done in cycle t, instr_done again in t+2 -> interrupt_queued=0 through t+2 and =1 in t+3. Repeat with di_cmd in t+1 -> stays 0.
- RETI: reti_cmd in cycle t -> ime=1 in t+1. ei_cmd&di_cmd together -> IME_OFF.
- Set-beats-clear: bus write IF=8'h00 in the same cycle as a rise on irq_req[1] -> IF=5'b00010. irq_req held high 10 cycles after an IF clear -> IF bit stays 0.
- Cancelled ack: IE cleared on the cycle before isr_ack -> vector_latched=8'h00, irq_taken=0, IF unchanged. NUM_IRQ=8, VECTOR_BASE=8'hC0, source 7 -> vector 8'hF8.
